// File: rtl/keyio_pkg.sv
// Shared constants for the key/switch I/O block: memory-mapped register
// addresses and KSTAT/KCTRL bit positions.
package keyio_pkg;
  localparam logic [15:0] ADDR_KEY   = 16'hFFF0;
  localparam logic [15:0] ADDR_SW    = 16'hFFF2;
  localparam logic [15:0] ADDR_KSTAT = 16'hFFF4;
  localparam logic [15:0] ADDR_KCTRL = 16'hFFF6;

  localparam int NKEY = 4;
  localparam int NSW  = 10;

  // KSTAT / KCTRL layout
  localparam int KST_PRESS_LSB = 0;  // [3:0] sticky press flags
  localparam int KST_OVR_LSB   = 4;  // [7:4] overrun flags
  localparam int KST_SWCHG     = 8;  // [8]   switch-change flag
  localparam int KST_W         = 9;
endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, stability counter and debounced output.
// upd_o pulses on the cycle the debounced value is about to flip.
module debounce_bit #(
  parameter int   DEB_CYCLES = 500000,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw_i,
  output logic deb_o,
  output logic upd_o
);
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic          s1_q, s2_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized value disagrees with the output;
  // the output flips on the cycle the count would reach DEB_CYCLES.
  always_comb begin
    upd_o = (s2_q != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    deb_d = upd_o ? s2_q : deb_q;
    cnt_d = (s2_q == deb_q || upd_o) ? '0 : cnt_q + 1'b1;
  end

  // Synchronizer, counter and debounced state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      deb_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;
endmodule

// File: rtl/key_sw_io_ctrl.sv
// Memory-mapped key/switch controller: debounced keys (FFF0), switches (FFF2),
// W1C status KSTAT (FFF4), irq enables KCTRL (FFF6), registered irq.
// Optional feature macro: KEYIO_SW_CHANGE_EN (switch-change flag in KSTAT[8]).
module key_sw_io_ctrl
  import keyio_pkg::*;
#(
  parameter int DBITS      = 16,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  output logic             sel,
  output logic [DBITS-1:0] rdata,
  output logic             irq
);
  logic [NKEY-1:0]  key_deb, key_upd, press;
  logic [NSW-1:0]   sw_deb, sw_upd;
  logic [7:0]       kstat_q, kstat_d, kstat_set;
  logic [7:0]       kctrl_q;
  logic [KST_W-1:0] kstat, kctrl;
  logic             wr_kstat, wr_kctrl, irq_q;

  // Keys idle high, switches idle low.
  for (genvar i = 0; i < NKEY; i++) begin : g_key
    debounce_bit #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb (
      .clk(clk), .rstn(rstn), .raw_i(key_in[i]), .deb_o(key_deb[i]), .upd_o(key_upd[i]));
  end
  for (genvar i = 0; i < NSW; i++) begin : g_sw
    debounce_bit #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb (
      .clk(clk), .rstn(rstn), .raw_i(sw_in[i]), .deb_o(sw_deb[i]), .upd_o(sw_upd[i]));
  end

  assign sel = (addr == DBITS'(ADDR_KEY))   || (addr == DBITS'(ADDR_SW)) ||
               (addr == DBITS'(ADDR_KSTAT)) || (addr == DBITS'(ADDR_KCTRL));
  assign wr_kstat = we && (addr == DBITS'(ADDR_KSTAT));
  assign wr_kctrl = we && (addr == DBITS'(ADDR_KCTRL));

  // A flip of a currently-high debounced key is a press.
  assign press = key_upd & key_deb;

  // Press/overrun flags: set wins over the same-cycle W1C.
  always_comb begin
    kstat_set = {press & kstat_q[KST_PRESS_LSB +: NKEY], press};
    kstat_d   = (kstat_q & ~(wr_kstat ? wdata[7:0] : 8'h00)) | kstat_set;
  end

  // Press/overrun status and low enable bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kstat_q <= '0;
      kctrl_q <= '0;
    end else begin
      kstat_q <= kstat_d;
      if (wr_kctrl) kctrl_q <= wdata[7:0];
    end
  end

`ifdef KEYIO_SW_CHANGE_EN
  logic swchg_q, swen_q;

  // Switch-change flag and its enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      swchg_q <= 1'b0;
      swen_q  <= 1'b0;
    end else begin
      swchg_q <= (swchg_q && !(wr_kstat && wdata[KST_SWCHG])) || (|sw_upd);
      if (wr_kctrl) swen_q <= wdata[KST_SWCHG];
    end
  end

  assign kstat = {swchg_q, kstat_q};
  assign kctrl = {swen_q, kctrl_q};
`else
  logic unused_sw;
  assign unused_sw = ^{sw_upd, wdata[KST_SWCHG]};
  assign kstat = {1'b0, kstat_q};
  assign kctrl = {1'b0, kctrl_q};
`endif

  // irq lags the status/enable change by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= |(kstat & kctrl);
  end
  assign irq = irq_q;

  // Combinational read mux; unmapped addresses read 0.
  always_comb begin
    rdata = '0;
    if      (addr == DBITS'(ADDR_KEY))   rdata = DBITS'({12'b0, key_deb});
    else if (addr == DBITS'(ADDR_SW))    rdata = DBITS'({6'b0, sw_deb});
    else if (addr == DBITS'(ADDR_KSTAT)) rdata = DBITS'({7'b0, kstat});
    else if (addr == DBITS'(ADDR_KCTRL)) rdata = DBITS'({7'b0, kctrl});
  end

  logic unused_wd;
  assign unused_wd = ^wdata[DBITS-1:KST_W];
endmodule

// File: tb/tb_key_sw_io_ctrl.sv
// Scoreboard bench for key_sw_io_ctrl with DEB_CYCLES=4.
module tb_key_sw_io_ctrl;
  localparam int DEB = 4;
`ifdef KEYIO_SW_CHANGE_EN
  localparam logic [15:0] SWCHG  = 16'h0100;
  localparam logic [15:0] CTRLFF = 16'h01FF;
`else
  localparam logic [15:0] SWCHG  = 16'h0000;
  localparam logic [15:0] CTRLFF = 16'h00FF;
`endif

  logic        clk, rstn, we, sel, irq;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [15:0] addr, wdata, rdata, stim_addr, mon_addr;
  logic        mon_on;

  assign addr = mon_on ? mon_addr : stim_addr;

  key_sw_io_ctrl #(.DBITS(16), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rstn(rstn), .key_in(key_in), .sw_in(sw_in), .addr(addr),
    .wdata(wdata), .we(we), .sel(sel), .rdata(rdata), .irq(irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [15:0] a;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic exp_rd(string nm, logic [15:0] a, logic [15:0] e);
    exp_t x;
    x.name = nm; x.is_irq = 1'b0; x.a = a; x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic exp_irq(string nm, logic e);
    exp_t x;
    x.name = nm; x.is_irq = 1'b1; x.a = 16'h0; x.exp = {15'b0, e};
    sb_q.push_back(x);
  endtask

  // Monitor: on each falling edge, drain the scoreboard against the DUT.
  initial mon_on = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_irq) begin
        got = {15'b0, irq};
      end else begin
        mon_addr = e.a;
        mon_on = 1'b1;
        #1;
        got = rdata;
        mon_on = 1'b0;
      end
      n_vec++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [15:0] a, logic [15:0] d);
    stim_addr = a; wdata = d; we = 1'b1;
    step(1);
    we = 1'b0; stim_addr = 16'h0000; wdata = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; key_in = 4'hF; sw_in = 10'h000; we = 1'b0;
    stim_addr = 16'h0000; wdata = 16'h0000;
    step(2);
    exp_rd("rst_key", 16'hFFF0, 16'h000F);
    exp_rd("rst_sw", 16'hFFF2, 16'h0000);
    exp_rd("rst_kstat", 16'hFFF4, 16'h0000);
    exp_rd("rst_kctrl", 16'hFFF6, 16'h0000);
    exp_irq("rst_irq", 1'b0);
    rstn = 1'b1;
    step(3);
    exp_rd("unmapped", 16'hFFF8, 16'h0000);

    // key1 press: visible exactly 2+DEB cycles later
    key_in = 4'hD;
    step(5);
    exp_rd("k1_early_key", 16'hFFF0, 16'h000F);
    exp_rd("k1_early_kstat", 16'hFFF4, 16'h0000);
    step(1);
    exp_rd("k1_key", 16'hFFF0, 16'h000D);
    exp_rd("k1_kstat", 16'hFFF4, 16'h0002);
    key_in = 4'hF;
    step(7);
    exp_rd("k1_rel_key", 16'hFFF0, 16'h000F);
    exp_rd("k1_rel_kstat", 16'hFFF4, 16'h0002);
    wr(16'hFFF4, 16'h0002);
    exp_rd("k1_w1c", 16'hFFF4, 16'h0000);

    // glitch of 3 cycles on key0 is discarded
    key_in = 4'hE;
    step(3);
    key_in = 4'hF;
    step(10);
    exp_rd("glitch_key", 16'hFFF0, 16'h000F);
    exp_rd("glitch_kstat", 16'hFFF4, 16'h0000);

    // KCTRL writable bits, ignored writes
    wr(16'hFFF6, 16'hFFFF);
    exp_rd("kctrl_ff", 16'hFFF6, CTRLFF);
    wr(16'hFFF6, 16'h0001);
    wr(16'hFFF0, 16'h0000);
    wr(16'h1234, 16'hFFFF);
    exp_rd("kctrl_01", 16'hFFF6, 16'h0001);
    exp_rd("wr_key_ign", 16'hFFF0, 16'h000F);

    // irq follows KSTAT[0] by one cycle, drops one cycle after W1C
    key_in = 4'hE;
    step(6);
    exp_rd("irq_kstat", 16'hFFF4, 16'h0001);
    exp_irq("irq_lag", 1'b0);
    step(1);
    exp_irq("irq_set", 1'b1);
    wr(16'hFFF4, 16'h0001);
    exp_rd("irq_w1c_kstat", 16'hFFF4, 16'h0000);
    exp_irq("irq_w1c_lag", 1'b1);
    step(1);
    exp_irq("irq_clr", 1'b0);
    key_in = 4'hF;
    step(7);

    // overrun: second press without clear
    key_in = 4'hE; step(7); key_in = 4'hF; step(7);
    key_in = 4'hE;
    step(6);
    exp_rd("ovr_kstat", 16'hFFF4, 16'h0011);
    key_in = 4'hF; step(7);
    // W1C on the same edge as a press: set wins
    key_in = 4'hE;
    step(5);
    wr(16'hFFF4, 16'h0001);
    exp_rd("w1c_vs_set", 16'hFFF4, 16'h0011);
    wr(16'hFFF4, 16'hFFFF);
    exp_rd("clr_all", 16'hFFF4, 16'h0000);
    key_in = 4'hF; step(7);

    // switches
    sw_in = 10'h005;
    step(5);
    exp_rd("sw_early", 16'hFFF2, 16'h0000);
    step(1);
    exp_rd("sw_val", 16'hFFF2, 16'h0005);
    exp_rd("sw_kstat", 16'hFFF4, SWCHG);
    wr(16'hFFF4, 16'hFFFF);

    // reset in the middle of a debounce window
    key_in = 4'hE; step(7);
    exp_irq("pre_rst_irq", 1'b1);
    key_in = 4'hF; step(3);
    rstn = 1'b0;
    #1;
    exp_rd("mrst_kstat", 16'hFFF4, 16'h0000);
    exp_rd("mrst_key", 16'hFFF0, 16'h000F);
    exp_rd("mrst_kctrl", 16'hFFF6, 16'h0000);
    exp_irq("mrst_irq", 1'b0);
    key_in = 4'hE;
    step(2);
    rstn = 1'b1;
    step(5);
    exp_rd("post_rst_early", 16'hFFF0, 16'h000F);
    exp_rd("post_rst_sw_early", 16'hFFF2, 16'h0000);
    step(1);
    exp_rd("post_rst_key", 16'hFFF0, 16'h000E);
    exp_rd("post_rst_sw", 16'hFFF2, 16'h0005);
    exp_rd("post_rst_kstat", 16'hFFF4, 16'h0001 | SWCHG);

    step(2);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) step(1);
    if (sb_q.size() > 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
